// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | logic_unit_arbiter                                                       |
// | Round-robin sequencer sharing one bitwise logic unit among requesters.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module logic_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [WIDTH*N_REQ-1:0] req_a,
  input  logic [WIDTH*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  output logic [1:0]             resp_id,
  output logic [WIDTH-1:0]       resp_data,
  input  logic                   resp_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [1:0] c_LAST = 2'(N_REQ - 1);
  localparam logic [2:0] c_NREQ = 3'(N_REQ);

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [1:0]       r_win;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_resp_id;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_valid;
  logic             r_busy;

  logic             w_found;
  logic [1:0]       w_win;
  logic [2:0]       w_idx;
  logic [WIDTH-1:0] w_result;

  // Scan upward from the rotating pointer, wrapping at N_REQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 3'd0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + 3'(k);
      if (w_idx >= c_NREQ) begin
        w_idx = w_idx - c_NREQ;
      end
      if (!w_found && req_valid[w_idx[1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[1:0];
      end
    end
  end

  // Gated by reset_n so the grant vanishes the moment reset is asserted.
  always_comb begin
    req_ready = '0;
    if (reset_n && (r_state == S_IDLE) && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      2'd0:    w_result = ~r_a;
      2'd1:    w_result = r_a & r_b;
      2'd2:    w_result = r_a | r_b;
      default: w_result = {{(WIDTH-1){1'b0}}, |r_a};
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_ptr        <= 2'd0;
      r_win        <= 2'd0;
      r_op         <= 2'd0;
      r_a          <= '0;
      r_b          <= '0;
      r_resp_id    <= 2'd0;
      r_resp_data  <= '0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_win   <= w_win;
            r_op    <= req_op[2*int'(w_win) +: 2];
            r_a     <= req_a[WIDTH*int'(w_win) +: WIDTH];
            r_b     <= req_b[WIDTH*int'(w_win) +: WIDTH];
            r_ptr   <= (w_win == c_LAST) ? 2'd0 : w_win + 2'd1;
            r_busy  <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_resp_data  <= w_result;
          r_resp_id    <= r_win;
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_logic_unit_arbiter                                                    |
// | Self-checking bench for logic_unit_arbiter. Revision: 1.0                |
// +--------------------------------------------------------------------------+
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [1:0]     resp_id;
  logic [W-1:0]   resp_data;
  logic           resp_ready;
  logic           busy;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;

  logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      0:       return ~a;
      1:       return a & b;
      2:       return a | b;
      default: return (a != 0) ? W'(1) : W'(0);
    endcase
  endfunction

  function automatic int ref_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [W-1:0] exp_of(input int i);
    return ref_op(int'(req_op[2*i +: 2]), req_a[W*i +: W], req_b[W*i +: W]);
  endfunction

  task automatic set_req(input int i, input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op[2*i +: 2] = 2'(op);
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic rand_payloads();
    for (int i = 0; i < N; i++) begin
      set_req(i, int'($urandom_range(0, 3)), W'($urandom), W'($urandom));
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req_valid = '1; resp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0 || resp_id !== 2'd0 || resp_data !== '0) begin
      failures++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b id=%0d data=%h, required all zero",
               resp_valid, busy, req_ready, resp_id, resp_data);
    end
    @(negedge clk); @(negedge clk);
    req_valid = '0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b valid=%b ready=%b, required 0 0 0", busy, resp_valid, req_ready);
    end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [W-1:0] e;
    rand_payloads();
    req_valid = '1; resp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      checks++;
      if (req_ready !== onehot(order[g]) || ref_winner(req_valid, m_ptr) != order[g]) begin
        failures++;
        $display("FAIL rr_grant%0d: ready=%b, required %b", g, req_ready, onehot(order[g]));
      end
      e = exp_of(order[g]);
      @(negedge clk); #1;
      checks++;
      if (req_ready !== '0 || busy !== 1'b1 || resp_valid !== 1'b0) begin
        failures++;
        $display("FAIL rr_exec%0d: ready=%b busy=%b valid=%b, required 0000 1 0", g, req_ready, busy, resp_valid);
      end
      if (g == 4) req_valid = '0;
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(order[g]) || resp_data !== e) begin
        failures++;
        $display("FAIL rr_resp%0d: valid=%b id=%0d data=%h, required 1 %0d %h", g, resp_valid, resp_id, resp_data, order[g], e);
      end
      @(negedge clk);
      m_ptr = (order[g] + 1) % N;
    end
  endtask

  task automatic test_ops();
    int           t_id  [5] = '{0, 2, 2, 1, 3};
    int           t_op  [5] = '{0, 1, 2, 3, 3};
    logic [W-1:0] t_a   [5] = '{16'h00FF, 16'hF0F0, 16'hF0F0, 16'h0000, 16'h8000};
    logic [W-1:0] t_b   [5] = '{16'h1234, 16'h3C3C, 16'h3C3C, 16'hFFFF, 16'hFFFF};
    logic [W-1:0] t_exp [5] = '{16'hFF00, 16'h3030, 16'hFCFC, 16'h0000, 16'h0001};
    resp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      req_valid = '0;
      set_req(t_id[n], t_op[n], t_a[n], t_b[n]);
      req_valid[t_id[n]] = 1'b1;
      #1;
      checks++;
      if (req_ready !== onehot(t_id[n])) begin
        failures++;
        $display("FAIL op%0d_grant: ready=%b, required %b", n, req_ready, onehot(t_id[n]));
      end
      @(negedge clk);
      req_valid = '0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL op%0d_exec: valid=%b busy=%b, required 0 1", n, resp_valid, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(t_id[n]) || resp_data !== t_exp[n]) begin
        failures++;
        $display("FAIL op%0d_resp: valid=%b id=%0d data=%h, required 1 %0d %h", n, resp_valid, resp_id, resp_data, t_id[n], t_exp[n]);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL op%0d_done: valid=%b busy=%b, required 0 0", n, resp_valid, busy);
      end
      m_ptr = (t_id[n] + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e0, e1;
    resp_ready = 1'b0;
    set_req(0, 1, 16'hA5A5, 16'h0FF0);
    set_req(1, 2, 16'h1200, 16'h0034);
    e0 = 16'h05A0; e1 = 16'h1234;
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_grant0: ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== e0 || req_ready !== '0) begin
        failures++;
        $display("FAIL bp_hold%0d: valid=%b id=%0d data=%h ready=%b, required 1 0 %h 0000", c, resp_valid, resp_id, resp_data, req_ready, e0);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_release: valid=%b ready=%b, required 0 0010", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== e1) begin
      failures++;
      $display("FAIL bp_resp1: valid=%b id=%0d data=%h, required 1 1 %h", resp_valid, resp_id, resp_data, e1);
    end
    @(negedge clk);
    m_ptr = 2;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e;
    resp_ready = 1'b1;
    set_req(2, 0, 16'h1357, 16'h0000);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL ar_grant: ready=%b, required 0100", req_ready);
    end
    @(negedge clk);
    rand_payloads();
    req_valid = '1;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      failures++;
      $display("FAIL ar_clear: valid=%b busy=%b ready=%b, required 0 0 0000", resp_valid, busy, req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ar_noresp: valid=%b busy=%b, required 0 0", resp_valid, busy);
    end
    @(negedge clk);
    #2 reset_n = 1'b1;
    m_ptr = 0;
    e = exp_of(0);
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL ar_first_grant: ready=%b, required 0001", req_ready);
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_data !== e) begin
      failures++;
      $display("FAIL ar_resp: valid=%b id=%0d data=%h, required 1 0 %h", resp_valid, resp_id, resp_data, e);
    end
    @(negedge clk);
    m_ptr = 1;
  endtask

  task automatic test_random();
    logic [N-1:0] mask;
    logic [W-1:0] e;
    int           win, stall;
    for (int n = 0; n < 40; n++) begin
      rand_payloads();
      mask  = N'($urandom_range(1, (1 << N) - 1));
      stall = int'($urandom_range(0, 3));
      req_valid  = mask;
      resp_ready = $urandom_range(0, 1) != 0;
      win = ref_winner(mask, m_ptr);
      e   = exp_of(win);
      #1;
      checks++;
      if (req_ready !== onehot(win)) begin
        failures++;
        $display("FAIL rnd%0d_grant: ready=%b, required %b", n, req_ready, onehot(win));
      end
      @(negedge clk);
      req_valid[win] = 1'b0;
      resp_ready = (stall == 0);
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
        if (s == stall) resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 2'(win) || resp_data !== e || req_ready !== '0) begin
          failures++;
          $display("FAIL rnd%0d_resp: valid=%b id=%0d data=%h ready=%b, required 1 %0d %h 0000", n, resp_valid, resp_id, resp_data, req_ready, win, e);
        end
        @(negedge clk);
      end
      req_valid = '0;
      m_ptr = (win + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_ops();
    test_backpressure();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
